// File: rtl/flt2int_if.sv
// ---------------------------------------------------------------------------
// flt2int_if
// Start/done handshake bundle for the flt2int half-float to integer converter.
//   start    request pulse, sampled only while the converter is idle
//   flt_in   16-bit half-precision operand {sgn, exp[4:0], mant[9:0]}
//   busy     converter is working (every state except idle)
//   done     one-cycle pulse, int_out/ovf valid from this cycle on
//   int_out  16-bit sign-magnitude result {sgn, mag[14:0]}
//   ovf      magnitude saturated to 0x7FFF
// master: the requester (software/bench); slave: the converter.
// ---------------------------------------------------------------------------
interface flt2int_if;
  logic        start;
  logic [15:0] flt_in;
  logic        busy;
  logic        done;
  logic [15:0] int_out;
  logic        ovf;

  modport master (
    output start, flt_in,
    input  busy, done, int_out, ovf
  );

  modport slave (
    input  start, flt_in,
    output busy, done, int_out, ovf
  );
endinterface

// File: rtl/flt2int.sv
// ---------------------------------------------------------------------------
// flt2int
// Sequential half-precision float to 16-bit sign-magnitude integer converter.
// The significand is aligned one bit per cycle (right for small exponents,
// left for large ones), optionally rounded, then written out with a done
// pulse. Latency from the accepting edge to done is n+1 cycles (n <= 11).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any conversion, clears outputs
//   bus    flt2int_if.slave (start, flt_in, busy, done, int_out, ovf)
//
// Build option:
//   FLT2INT_ROUND_EN  defined   -> round-to-nearest-even on right shifts
//                     undefined -> truncate toward zero (guard/sticky absent)
// ---------------------------------------------------------------------------
module flt2int (
  input  logic      clk,
  input  logic      reset,
  flt2int_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [14:0] r_mag;
  logic [3:0]  r_cnt;
  logic        r_left;
  logic        r_sgn;
  logic        r_ovf_pend;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_int_out;
  logic        r_ovf;

  // Operand fields and hidden-bit significand.
  logic        w_sgn;
  logic [4:0]  w_exp;
  logic [9:0]  w_mant;
  logic [10:0] w_sig;
  logic [4:0]  w_rdist;
  logic [4:0]  w_ldist;

  assign w_sgn   = bus.flt_in[15];
  assign w_exp   = bus.flt_in[14:10];
  assign w_mant  = bus.flt_in[9:0];
  assign w_sig   = {1'b1, w_mant};
  assign w_rdist = 5'd25 - w_exp;   // meaningful for exp 14..24 (1..11)
  assign w_ldist = w_exp - 5'd25;   // meaningful for exp 26..29 (1..4)

  // Load-time classification of the exponent.
  logic [14:0] w_ld_mag;
  logic [3:0]  w_ld_cnt;
  logic        w_ld_left;
  logic        w_ld_ovf;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the if-chain leaves a value unassigned (no latch).
    w_ld_mag  = '0;
    w_ld_cnt  = '0;
    w_ld_left = 1'b0;
    w_ld_ovf  = 1'b0;
    if (w_exp <= 5'd13) begin
      // exp 0 flushes subnormals; exp 1..13 is below 0.5 in magnitude.
      w_ld_mag = '0;
    end else if (w_exp <= 5'd24) begin
      w_ld_mag = {4'b0, w_sig};
      w_ld_cnt = w_rdist[3:0];
    end else if (w_exp == 5'd25) begin
      w_ld_mag = {4'b0, w_sig};
    end else if (w_exp <= 5'd29) begin
      w_ld_mag  = {4'b0, w_sig};
      w_ld_cnt  = w_ldist[3:0];
      w_ld_left = 1'b1;
    end else begin
      // exp 30 and 31 (inf/NaN) saturate.
      w_ld_mag = 15'h7FFF;
      w_ld_ovf = 1'b1;
    end
  end

  // Final magnitude written in ROUND. Neither path can overflow 15 bits:
  // left shifts top out at 32752, rounded right shifts at 1024.
  logic [14:0] w_mag_final;

`ifdef FLT2INT_ROUND_EN
  logic r_guard;   // last bit shifted out
  logic r_sticky;  // OR of every bit shifted out before the guard bit
  logic w_round_up;

  assign w_round_up  = r_guard & (r_sticky | r_mag[0]);
  assign w_mag_final = r_mag + {14'b0, w_round_up};
`else
  assign w_mag_final = r_mag;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_left     <= 1'b0;
      r_sgn      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_int_out  <= '0;
      r_ovf      <= 1'b0;
`ifdef FLT2INT_ROUND_EN
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sgn      <= w_sgn;
            r_mag      <= w_ld_mag;
            r_cnt      <= w_ld_cnt;
            r_left     <= w_ld_left;
            r_ovf_pend <= w_ld_ovf;
            r_busy     <= 1'b1;
`ifdef FLT2INT_ROUND_EN
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
`endif
            r_state    <= (w_ld_cnt != 4'd0) ? S_SHIFT : S_ROUND;
          end
        end

        S_SHIFT: begin
          if (r_left) begin
            r_mag <= {r_mag[13:0], 1'b0};
          end else begin
            r_mag <= {1'b0, r_mag[14:1]};
`ifdef FLT2INT_ROUND_EN
            // The previous guard bit joins the sticky set as a new one drops.
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
`endif
          end
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_ROUND;
          end
        end

        S_ROUND: begin
          r_int_out <= {r_sgn, w_mag_final};
          r_ovf     <= r_ovf_pend;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.int_out = r_int_out;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_flt2int.sv
// ---------------------------------------------------------------------------
// tb_flt2int
// Scoreboard bench for flt2int: the driver pushes the hand-computed result,
// the monitor pops and compares on every done pulse. Expected rounding
// results follow the FLT2INT_ROUND_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_flt2int;

`ifdef FLT2INT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] out;
    logic        ovf;
    int          lat;
    int          start_cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] flt;
    logic [15:0] out;
    logic        ovf;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  flt2int_if bus ();

  flt2int dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  logic prev_done;
  initial prev_done = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_pulse_width", {31'b0, bus.done}, 32'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got int_out 0x%0h, expected no result", bus.int_out);
        end else begin
          e = sb.pop_front();
          check({e.name, "_int_out"}, {16'b0, bus.int_out}, {16'b0, e.out});
          check({e.name, "_ovf"}, {31'b0, bus.ovf}, {31'b0, e.ovf});
          check({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
        end
      end
      prev_done = bus.done;
    end
  end

  // Waits until the converter is idle and all expected results are consumed.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d, expected idle", name, bus.busy, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input string name, input logic [15:0] f, input logic [15:0] eo,
                       input logic eov, input int lat);
    exp_t e;
    @(negedge clk);
    bus.flt_in = f;
    bus.start  = 1'b1;
    e.name = name; e.out = eo; e.ovf = eov; e.lat = lat; e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start  = 1'b0;
    bus.flt_in = 16'h0000;

    vecs = '{
      '{"one",        16'h3C00, 16'h0001, 1'b0, 11},
      '{"neg_one",    16'hBC00, 16'h8001, 1'b0, 11},
      '{"round_trip", 16'h7783, 16'h7830, 1'b0, 5},
      '{"ovf_32768",  16'h7800, 16'h7FFF, 1'b1, 1},
      '{"ovf_inf",    16'h7C00, 16'h7FFF, 1'b1, 1},
      '{"ovf_neg",    16'hFC00, 16'hFFFF, 1'b1, 1},
      '{"half",       16'h3800, 16'h0000, 1'b0, 12},
      '{"one_half",   16'h3E00, ROUND ? 16'h0002 : 16'h0001, 1'b0, 11},
      '{"two_half",   16'h4100, 16'h0002, 1'b0, 10},
      '{"three_qtr",  16'h3A00, ROUND ? 16'h0001 : 16'h0000, 1'b0, 12},
      '{"zero",       16'h0000, 16'h0000, 1'b0, 1},
      '{"subnormal",  16'h0123, 16'h0000, 1'b0, 1},
      '{"small",      16'h3000, 16'h0000, 1'b0, 1},
      '{"neg_zero",   16'h8000, 16'h8000, 1'b0, 1},
      '{"exp25",      16'h6400, 16'h0400, 1'b0, 1},
      '{"max_left",   16'hF7FF, 16'hFFF0, 1'b0, 5}
    };

    repeat (2) @(negedge clk);
    check("reset_busy",    {31'b0, bus.busy},    32'd0);
    check("reset_done",    {31'b0, bus.done},    32'd0);
    check("reset_int_out", {16'b0, bus.int_out}, 32'd0);
    check("reset_ovf",     {31'b0, bus.ovf},     32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].flt, vecs[i].out, vecs[i].ovf, vecs[i].lat);
      wait_idle(vecs[i].name);
    end

    // A start pulse while busy must be ignored; only one result appears.
    issue("ignored_first", 16'h3C00, 16'h0001, 1'b0, 11);
    repeat (2) @(negedge clk);
    bus.flt_in = 16'h7800;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_idle("ignored");
    repeat (4) @(negedge clk);
    check("ignored_hold_int_out", {16'b0, bus.int_out}, 32'h0001);
    check("ignored_hold_ovf",     {31'b0, bus.ovf},     32'd0);

    // Leave a saturated result in the output registers, then abort mid-shift.
    issue("pre_reset_ovf", 16'h7C00, 16'h7FFF, 1'b1, 1);
    wait_idle("pre_reset_ovf");
    issue("aborted", 16'h3C00, 16'h0001, 1'b0, 11);
    repeat (3) @(negedge clk);
    sb.delete();
    reset = 1'b1;
    #1;
    check("abort_busy",    {31'b0, bus.busy},    32'd0);
    check("abort_done",    {31'b0, bus.done},    32'd0);
    check("abort_int_out", {16'b0, bus.int_out}, 32'd0);
    check("abort_ovf",     {31'b0, bus.ovf},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue("after_reset", 16'h3C00, 16'h0001, 1'b0, 11);
    wait_idle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/flt2int.md
# flt2int

Sequential half-precision-float to sign-magnitude integer converter. It is the inverse stage of the int2flt conversion path and consumes the 16-bit float word that int2flt writes to data memory.
- Input format: 1 sign, 5-bit exponent (bias 15), 10-bit mantissa with hidden bit.
- Output format: 16-bit sign-magnitude integer.

The block aligns the significand one bit per cycle, optionally rounds, and reports overflow. Software and the bench drive it through a start/done handshake.

## Interface
- No parameters; widths are fixed at 16-bit in, 16-bit out.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; returns the FSM to IDLE and clears all outputs.
- start  input  1  request pulse; sampled only in IDLE.
- flt_in  input  16  operand {sgn, exp[4:0], mant[9:0]}; sampled on the edge where start is accepted.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; int_out and ovf are valid from this cycle on.
- int_out  output  16  {sgn, mag[14:0]}; held until the next accepted start.
- ovf  output  1  magnitude saturated; valid with done, held with int_out.

## Operation
- Internal significand: sig = {1, mant} for exp != 0. The value is sig * 2^(exp-25).
- States are IDLE, SHIFT, ROUND, DONE. The load/classify step happens on the accepting edge.
- On start in IDLE, capture sgn and classify exp:
  - exp == 0: zero (subnormals flush). mag = 0, n = 0.
  - exp <= 13: zero (|value| < 0.5). mag = 0, n = 0.
  - exp 14..24: right shift by n = 25-exp (11..1). mag = sig.
  - exp == 25: n = 0, mag = sig.
  - exp 26..29: left shift by n = exp-25 (1..4).
  - exp >= 30 (includes 31): ovf = 1, mag = 0x7FFF, n = 0.
- Next state after load: SHIFT if n > 0, otherwise ROUND.
- SHIFT: one shift of mag per cycle, count decrements. The shift that drops count to 0 also moves the FSM to ROUND.
- Right shifts track guard (last bit shifted out) and sticky (OR of all earlier bits shifted out). Guard and sticky are cleared at load.
- ROUND: applies rounding (see Configuration), writes int_out = {sgn, mag}, latches ovf, then moves to DONE.
- DONE: done = 1 for one cycle, then the FSM returns to IDLE.
- The sign always passes through, including zero results: 0x8000 in gives 0x8000 out.
- Widths cannot overflow:
  - Maximum left-shift result is 2047 << 4 = 32752.
  - Maximum rounded right-shift result is 1024.
  - mag is 15 bits.
- start outside IDLE is ignored, with no queuing.
- An asynchronous reset mid-operation aborts the conversion. int_out is 0, ovf is 0, done is 0, and the FSM is in IDLE; no partial result is written.
- Reset values: busy 0, done 0, int_out 0x0000, ovf 0.

## Timing
- start is accepted at edge k.
- Edges k+1..k+n perform the shifts.
- Edge k+n+1 executes ROUND and updates int_out.
- done is high from edge k+n+1 to edge k+n+2. Latency from start edge to done is n+1 cycles, with a maximum of 12.
- busy is high from edge k until edge k+n+2.
- The earliest next start is accepted at the edge after the FSM returns to IDLE, i.e. k+n+3.

## Configuration
- FLT2INT_ROUND_EN defined: ROUND applies round-to-nearest-even.
  - Increment mag if guard && (sticky || mag[0]).
  - Example: exp == 14 yields 1 unless mant == 0, in which case it yields 0.
- FLT2INT_ROUND_EN undefined: truncate toward zero. The guard/sticky logic is not compiled, and ROUND only writes the outputs.
- Timing is identical in both builds.

## Test plan
- Basic and negative values:
  - flt_in = 0x3C00 (1.0) -> int_out 0x0001, ovf 0, done 11 cycles after start.
  - flt_in = 0xBC00 -> int_out 0x8001.
- int2flt round trip: flt_in = 0x7783 (int2flt output for 30767) -> int_out 0x7830 (30768), ovf 0, done 5 cycles after start.
- Overflow: flt_in = 0x7800 (32768) and 0x7C00 -> int_out 0x7FFF, ovf 1, done 1 cycle after start.
- Rounding:

  | flt_in | Value | ROUND_EN int_out | Truncate int_out |
  |---|---|---|---|
  | 0x3800 | 0.5 | 0x0000 | 0x0000 |
  | 0x3E00 | 1.5 | 0x0002 | 0x0001 |
  | 0x4100 | 2.5 | 0x0002 | 0x0002 |
  | 0x3A00 | 0.75 | 0x0001 | 0x0000 |

- Zero and small values: flt_in = 0x0000, 0x0123 and 0x3000 -> int_out 0x0000, done 1 cycle after start.
- Handshake and reset:
  - A second start pulse while busy is ignored; the first result is unchanged.
  - reset asserted during SHIFT for 0x3C00 -> busy, done, int_out and ovf are all 0 immediately. A following start converts correctly.
